// File: rtl/video_timing_pkg.sv
// Mode table and derived timing for the multi-mode video timing generator.
// Everything here is constant; the RTL only ever evaluates it per active mode.
package video_timing_pkg;

  typedef enum logic [1:0] {
    MODE_640x480   = 2'd0,
    MODE_800x600   = 2'd1,
    MODE_1280x720  = 2'd2,
    MODE_1920x1080 = 2'd3
  } mode_t;

  typedef struct packed {
    int   res;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
  } timing_t;

  // Start of line/frame, sync window [s_sta, s_end) and polarity, ready for the counters.
  typedef struct packed {
    int   h_res;
    int   h_sta;
    int   hs_sta;
    int   hs_end;
    logic h_pol;
    int   v_res;
    int   v_sta;
    int   vs_sta;
    int   vs_end;
    logic v_pol;
  } geom_t;

  function automatic timing_t mode_timing(input logic [1:0] mode);
    timing_t t;
    case (mode)
      MODE_800x600:   t = '{h: '{800, 40, 128, 88, 1'b1}, v: '{600, 1, 4, 23, 1'b1}};
      MODE_1280x720:  t = '{h: '{1280, 110, 40, 220, 1'b1}, v: '{720, 5, 5, 20, 1'b1}};
      MODE_1920x1080: t = '{h: '{1920, 88, 44, 148, 1'b1}, v: '{1080, 4, 5, 36, 1'b1}};
      default:        t = '{h: '{640, 16, 96, 48, 1'b0}, v: '{480, 10, 2, 33, 1'b0}};
    endcase
    return t;
  endfunction

  function automatic geom_t mode_geom(input logic [1:0] mode);
    timing_t t;
    geom_t   g;
    t        = mode_timing(mode);
    g.h_res  = t.h.res;
    g.h_sta  = -(t.h.fp + t.h.sync + t.h.bp);
    g.hs_sta = g.h_sta + t.h.fp;
    g.hs_end = g.hs_sta + t.h.sync;
    g.h_pol  = t.h.pol;
    g.v_res  = t.v.res;
    g.v_sta  = -(t.v.fp + t.v.sync + t.v.bp);
    g.vs_sta = g.v_sta + t.v.fp;
    g.vs_end = g.vs_sta + t.v.sync;
    g.v_pol  = t.v.pol;
    return g;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Multi-mode video timing generator: signed beam counters, sync/enable/strobes,
// and a two-state mode FSM that switches timing only on a strobed frame wrap.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CORDW     = 16,
  parameter int NUM_MODES = 4,
  parameter int DEF_MODE  = 0
) (
  input  logic                    i_pix_clk,
  input  logic                    i_rst_n,
  input  logic                    i_pix_stb,
  input  logic [1:0]              i_mode,
  input  logic                    i_mode_req,
  output logic [1:0]              o_mode,
  output logic                    o_mode_busy,
  output logic                    o_mode_err,
  output logic                    o_hs,
  output logic                    o_vs,
  output logic                    o_de,
  output logic                    o_frame,
  output logic                    o_line,
  output logic signed [CORDW-1:0] o_sx,
  output logic signed [CORDW-1:0] o_sy,
  output logic [CORDW-1:0]        o_h_res,
  output logic [CORDW-1:0]        o_v_res
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [1:0] DEF_CODE = 2'(DEF_MODE);
  localparam geom_t      DEF_G    = mode_geom(DEF_CODE);

  state_t                  state, state_next;
  logic [1:0]              mode, mode_next, pend_mode;
  logic signed [CORDW-1:0] sx, sy, sx_next, sy_next;
  logic signed [CORDW-1:0] h_sta, hs_sta, hs_end, v_sta, vs_sta, vs_end;
  logic [CORDW-1:0]        h_res, v_res;
  geom_t                   g;
  logic                    req_valid, line_end, frame_end, wrap;
  logic                    hs_next, vs_next, de_next, frame_next, line_next;

  assign req_valid = i_mode_req && (int'(i_mode) < NUM_MODES);
  assign line_end  = (sx == (h_res - CORDW'(1)));
  assign frame_end = line_end && (sy == (v_res - CORDW'(1)));
  assign wrap      = i_pix_stb && frame_end;

  // A request on the wrap cycle keeps the FSM in PEND for the following frame.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next = state;
    mode_next  = mode;
    case (state)
      IDLE: if (req_valid) state_next = PEND;
      PEND: begin
        if (wrap) mode_next = pend_mode;
        if (wrap && !req_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Geometry of the mode that will be active after this clock.
  assign g      = mode_geom(mode_next);
  assign h_sta  = CORDW'(g.h_sta);
  assign hs_sta = CORDW'(g.hs_sta);
  assign hs_end = CORDW'(g.hs_end);
  assign v_sta  = CORDW'(g.v_sta);
  assign vs_sta = CORDW'(g.vs_sta);
  assign vs_end = CORDW'(g.vs_end);

  always_comb begin
    sx_next = sx;
    sy_next = sy;
    if (i_pix_stb) begin
      if (line_end) begin
        sx_next = h_sta;
        sy_next = frame_end ? v_sta : sy + CORDW'(1);
      end else begin
        sx_next = sx + CORDW'(1);
      end
    end
    hs_next    = ((sx_next >= hs_sta) && (sx_next < hs_end)) ? g.h_pol : !g.h_pol;
    vs_next    = ((sy_next >= vs_sta) && (sy_next < vs_end)) ? g.v_pol : !g.v_pol;
    de_next    = !sx_next[CORDW-1] && !sy_next[CORDW-1];
    frame_next = (sx_next == h_sta) && (sy_next == v_sta);
    line_next  = (sx_next == h_sta);
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only; async reset loads the default mode.
    if (!i_rst_n) begin
      state      <= IDLE;
      mode       <= DEF_CODE;
      pend_mode  <= '0;
      sx         <= CORDW'(DEF_G.h_sta);
      sy         <= CORDW'(DEF_G.v_sta);
      h_res      <= CORDW'(DEF_G.h_res);
      v_res      <= CORDW'(DEF_G.v_res);
      o_hs       <= !DEF_G.h_pol;
      o_vs       <= !DEF_G.v_pol;
      o_de       <= 1'b0;
      o_frame    <= 1'b1;
      o_line     <= 1'b1;
      o_mode_err <= 1'b0;
    end else begin
      state      <= state_next;
      mode       <= mode_next;
      if (req_valid) pend_mode <= i_mode;
      sx         <= sx_next;
      sy         <= sy_next;
      h_res      <= CORDW'(g.h_res);
      v_res      <= CORDW'(g.v_res);
      o_hs       <= hs_next;
      o_vs       <= vs_next;
      o_de       <= de_next;
      o_frame    <= frame_next;
      o_line     <= line_next;
      o_mode_err <= i_mode_req && !req_valid;
    end
  end

  assign o_mode      = mode;
  assign o_mode_busy = (state == PEND);
  assign o_sx        = sx;
  assign o_sy        = sy;
  assign o_h_res     = h_res;
  assign o_v_res     = v_res;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen: a frame-index model checks two instances
// (four modes and two modes) every clock, with fast-forward to reach frame wraps.
module tb_video_timing_gen;

  localparam int T_HRES[4] = '{640, 800, 1280, 1920};
  localparam int T_HFP [4] = '{16, 40, 110, 88};
  localparam int T_HSY [4] = '{96, 128, 40, 44};
  localparam int T_HBP [4] = '{48, 88, 220, 148};
  localparam bit T_HPOL[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  localparam int T_VRES[4] = '{480, 600, 720, 1080};
  localparam int T_VFP [4] = '{10, 1, 5, 4};
  localparam int T_VSY [4] = '{2, 4, 5, 5};
  localparam int T_VBP [4] = '{33, 23, 20, 36};
  localparam bit T_VPOL[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  localparam int NMODES[2] = '{4, 2};

  logic clk = 1'b0;
  logic rst_n, stb, mode_req;
  logic [1:0] mode_in;

  logic [1:0]         mode_w[2];
  logic               busy_w[2], err_w[2], hs_w[2], vs_w[2], de_w[2], frame_w[2], line_w[2];
  logic signed [15:0] sx_w[2], sy_w[2];
  logic [15:0]        hres_w[2], vres_w[2];

  logic signed [15:0] ff_sx0, ff_sy0, ff_sx1, ff_sy1;

  int checks = 0;
  int errors = 0;
  int div_cnt = 0;

  // Reference model: active mode, position as a linear index within the frame, pending request.
  int m_mode[2], m_p[2], m_pendv[2];
  bit m_pend[2], m_err[2];

  video_timing_gen #(.CORDW(16), .NUM_MODES(4), .DEF_MODE(0)) u_dut0 (
    .i_pix_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_mode(mode_in), .i_mode_req(mode_req),
    .o_mode(mode_w[0]), .o_mode_busy(busy_w[0]), .o_mode_err(err_w[0]),
    .o_hs(hs_w[0]), .o_vs(vs_w[0]), .o_de(de_w[0]), .o_frame(frame_w[0]), .o_line(line_w[0]),
    .o_sx(sx_w[0]), .o_sy(sy_w[0]), .o_h_res(hres_w[0]), .o_v_res(vres_w[0])
  );

  video_timing_gen #(.CORDW(16), .NUM_MODES(2), .DEF_MODE(0)) u_dut1 (
    .i_pix_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_mode(mode_in), .i_mode_req(mode_req),
    .o_mode(mode_w[1]), .o_mode_busy(busy_w[1]), .o_mode_err(err_w[1]),
    .o_hs(hs_w[1]), .o_vs(vs_w[1]), .o_de(de_w[1]), .o_frame(frame_w[1]), .o_line(line_w[1]),
    .o_sx(sx_w[1]), .o_sy(sy_w[1]), .o_h_res(hres_w[1]), .o_v_res(vres_w[1])
  );

  initial forever #5 clk = ~clk;

  function automatic int htot(input int m);
    return T_HRES[m] + T_HFP[m] + T_HSY[m] + T_HBP[m];
  endfunction

  function automatic int vtot(input int m);
    return T_VRES[m] + T_VFP[m] + T_VSY[m] + T_VBP[m];
  endfunction

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_p[i] = 0; m_pend[i] = 1'b0; m_pendv[i] = 0; m_err[i] = 1'b0;
    end
  endtask

  task automatic compare(input int i);
    int m, ht, x, y, hbl, vbl;
    logic [4:0] ef;
    m   = m_mode[i];
    ht  = htot(m);
    x   = m_p[i] % ht;
    y   = m_p[i] / ht;
    hbl = T_HFP[m] + T_HSY[m] + T_HBP[m];
    vbl = T_VFP[m] + T_VSY[m] + T_VBP[m];
    ef[4] = (x >= T_HFP[m] && x < T_HFP[m] + T_HSY[m]) ? T_HPOL[m] : !T_HPOL[m];
    ef[3] = (y >= T_VFP[m] && y < T_VFP[m] + T_VSY[m]) ? T_VPOL[m] : !T_VPOL[m];
    ef[2] = (x >= hbl) && (y >= vbl);
    ef[1] = (m_p[i] == 0);
    ef[0] = (x == 0);
    check($sformatf("sx%0d", i), 64'(sx_w[i]), 64'(x - hbl));
    check($sformatf("sy%0d", i), 64'(sy_w[i]), 64'(y - vbl));
    check($sformatf("hs_vs_de_frame_line%0d", i),
          64'({hs_w[i], vs_w[i], de_w[i], frame_w[i], line_w[i]}), 64'(ef));
    check($sformatf("mode_busy_err%0d", i), 64'({mode_w[i], busy_w[i], err_w[i]}),
          64'({2'(m_mode[i]), m_pend[i], m_err[i]}));
    check($sformatf("res%0d", i), 64'({hres_w[i], vres_w[i]}), 64'({16'(T_HRES[m]), 16'(T_VRES[m])}));
  endtask

  task automatic step(input int i, input bit s, input bit r, input int code);
    bit wr;
    wr = s && (m_p[i] == htot(m_mode[i]) * vtot(m_mode[i]) - 1);
    if (s) m_p[i] = wr ? 0 : m_p[i] + 1;
    if (wr && m_pend[i]) begin
      m_mode[i] = m_pendv[i];
      m_pend[i] = 1'b0;
    end
    m_err[i] = r && (code >= NMODES[i]);
    if (r && code < NMODES[i]) begin
      m_pend[i]  = 1'b1;
      m_pendv[i] = code;
    end
  endtask

  // Jump both instances to k pixels before their frame wrap.
  task automatic fast_forward(input int k);
    int m, ht, x, y;
    for (int i = 0; i < 2; i++) begin
      m = m_mode[i];
      ht = htot(m);
      m_p[i] = ht * vtot(m) - k;
      x = m_p[i] % ht;
      y = m_p[i] / ht;
      if (i == 0) begin
        ff_sx0 = 16'(x - (T_HFP[m] + T_HSY[m] + T_HBP[m]));
        ff_sy0 = 16'(y - (T_VFP[m] + T_VSY[m] + T_VBP[m]));
      end else begin
        ff_sx1 = 16'(x - (T_HFP[m] + T_HSY[m] + T_HBP[m]));
        ff_sy1 = 16'(y - (T_VFP[m] + T_VSY[m] + T_VBP[m]));
      end
    end
    force u_dut0.sx = ff_sx0;
    force u_dut0.sy = ff_sy0;
    force u_dut1.sx = ff_sx1;
    force u_dut1.sy = ff_sy1;
    #1;
    release u_dut0.sx;
    release u_dut0.sy;
    release u_dut1.sx;
    release u_dut1.sy;
  endtask

  // Called at a falling edge: check, optionally fast-forward, drive, advance model, wait.
  task automatic run_cycle(input int kind, input bit allow_rand, input bit wrap_req,
                           input bit force_req, input int force_code, input bit do_ff, input int k);
    bit s, r;
    int code;
    compare(0);
    compare(1);
    if (do_ff) fast_forward(k);
    case (kind)
      0:       s = 1'b1;
      1:       s = (div_cnt == 0);
      default: s = 1'($urandom_range(0, 1));
    endcase
    div_cnt = (div_cnt + 1) % 4;
    r = 1'b0;
    code = 0;
    if (force_req) begin
      r = 1'b1; code = force_code;
    end else if (wrap_req && s && m_p[0] == htot(m_mode[0]) * vtot(m_mode[0]) - 1) begin
      r = 1'b1; code = int'($urandom_range(0, 3));
    end else if (allow_rand && $urandom_range(0, 149) == 0) begin
      r = 1'b1; code = int'($urandom_range(0, 3));
    end
    stb = s;
    mode_req = r;
    mode_in = 2'(code);
    step(0, s, r, code);
    step(1, s, r, code);
    @(negedge clk);
  endtask

  initial begin
    int kind, k, len;
    rst_n = 1'b0; stb = 1'b0; mode_req = 1'b0; mode_in = 2'd0;
    ff_sx0 = '0; ff_sy0 = '0; ff_sx1 = '0; ff_sy1 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_sx%0d", i), 64'(sx_w[i]), -64'sd160);
      check($sformatf("rst_sy%0d", i), 64'(sy_w[i]), -64'sd45);
      check($sformatf("rst_flags%0d", i), 64'({hs_w[i], vs_w[i], de_w[i], frame_w[i], line_w[i]}), 64'd27);
      check($sformatf("rst_mode%0d", i), 64'({mode_w[i], busy_w[i], err_w[i]}), 64'd0);
    end
    rst_n = 1'b1;

    for (int ph = 0; ph < 10 && errors < 25; ph++) begin
      kind = ph % 3;
      k = (kind == 0) ? int'($urandom_range(20, 2500)) :
          (kind == 1) ? int'($urandom_range(20, 600)) : int'($urandom_range(20, 1000));
      len = 300 + k * ((kind == 0) ? 1 : (kind == 1) ? 4 : 3) + 900;
      div_cnt = 0;
      for (int cyc = 0; cyc < len && errors < 25; cyc++) begin
        if (ph == 7 && cyc == 200) begin
          #2 rst_n = 1'b0;
          #1;
          check("async_rst_sx", 64'(sx_w[0]), -64'sd160);
          check("async_rst_sy", 64'(sy_w[0]), -64'sd45);
          check("async_rst_mode_busy", 64'({mode_w[0], busy_w[0]}), 64'd0);
          check("async_rst_frame", 64'(frame_w[0]), 64'd1);
          model_reset();
          @(negedge clk);
          rst_n = 1'b1;
        end
        run_cycle(kind, (ph != 6), ph[0],
                  (ph == 6 && cyc == 10) || (ph == 7 && cyc == 190),
                  (ph == 6) ? 3 : 2, (cyc == 300), k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
